uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares a single UART transmitter among N_REQ byte producers. Each requester offers one byte at a time over a req/ack handshake. The arbiter launches the winning byte into the transmitter, waits for frame completion, then rotates priority. It sits between the on-chip byte sources and the `uart_tx` instance, the transmit counterpart of the 8E1-framed (even-parity) receiver.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_pick.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame timing constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    localparam int unsigned CLK_PER_BIT = 868;
    localparam int unsigned FRAME_BITS  = 11;

    // One bit time of slack beyond an 8E1 frame before the watchdog fires.
    localparam int unsigned TIMEOUT_CYCLES_DEF = (FRAME_BITS + 1) * CLK_PER_BIT;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request strictly above
// `last_i`, wrapping around, via a double-width masked priority scan.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    logic [N_REQ-1:0]   mask;
    logic [2*N_REQ-1:0] dbl;
    int unsigned        pos;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            mask[i] = (i > 32'(last_i));
        end
        // Low half holds requests above the pointer, high half wraps to all.
        dbl   = {req_i, req_i & mask};
        any_o = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
            if (!any_o && dbl[i]) begin
                any_o = 1'b1;
                pos   = i;
            end
        end
        if (pos >= N_REQ) begin
            idx_o = IW'(pos - N_REQ);
        end else begin
            idx_o = IW'(pos);
        end
        gnt_o        = '0;
        gnt_o[idx_o] = any_o;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Optional burst lock is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned MAX_BURST      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [8*N_REQ-1:0]   i_data,
    output logic [N_REQ-1:0]     o_ack,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_byte,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done,
    output logic                 o_busy,
    output logic                 o_timeout
);

    localparam int unsigned IW  = $clog2(N_REQ);
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES);

    state_e           state_q;
    logic [N_REQ-1:0] ack_q;
    logic [N_REQ-1:0] grant_q;
    logic             start_q;
    logic [7:0]       byte_q;
    logic             timeout_q;
    logic [IW-1:0]    last_q;
    logic [IW-1:0]    w_q;
    logic [WDW-1:0]   wd_q;

    logic [N_REQ-1:0] rr_gnt;
    logic [IW-1:0]    rr_idx;
    logic             rr_any;

    logic [N_REQ-1:0] win_gnt_d;
    logic [IW-1:0]    win_idx_d;
    logic             win_any_d;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i  (i_req),
        .last_i (last_q),
        .gnt_o  (rr_gnt),
        .idx_o  (rr_idx),
        .any_o  (rr_any)
    );

`ifdef UART_ARB_LOCK_EN
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    logic          lock_q;
    logic [BW-1:0] burst_q;

    always_comb begin
        win_gnt_d = rr_gnt;
        win_idx_d = rr_idx;
        win_any_d = rr_any;
        // A locked owner still requesting overrides the rotating pointer.
        if (lock_q && i_req[w_q]) begin
            win_gnt_d      = '0;
            win_gnt_d[w_q] = 1'b1;
            win_idx_d      = w_q;
            win_any_d      = 1'b1;
        end
    end
`else
    always_comb begin
        win_gnt_d = rr_gnt;
        win_idx_d = rr_idx;
        win_any_d = rr_any;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ack_q     <= '0;
            grant_q   <= '0;
            start_q   <= 1'b0;
            byte_q    <= 8'h00;
            timeout_q <= 1'b0;
            last_q    <= IW'(N_REQ - 1);
            w_q       <= '0;
            wd_q      <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_q    <= 1'b0;
            burst_q   <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_any_d && !i_tx_busy) begin
                        byte_q  <= i_data[8*win_idx_d +: 8];
                        ack_q   <= win_gnt_d;
                        grant_q <= win_gnt_d;
                        w_q     <= win_idx_d;
                        state_q <= LAUNCH;
`ifdef UART_ARB_LOCK_EN
                        lock_q  <= 1'b0;
                        if (win_idx_d == w_q && burst_q != '0) begin
                            if (burst_q < BW'(MAX_BURST)) burst_q <= burst_q + 1'b1;
                        end else begin
                            burst_q <= BW'(1);
                        end
`endif
                    end
                end
                LAUNCH: begin
                    ack_q   <= '0;
                    start_q <= 1'b1;
                    wd_q    <= '0;
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    start_q <= 1'b0;
                    if (i_tx_done) begin
                        grant_q <= '0;
                        state_q <= IDLE;
`ifdef UART_ARB_LOCK_EN
                        if (i_req[w_q] && burst_q < BW'(MAX_BURST)) begin
                            lock_q <= 1'b1;
                        end else begin
                            last_q <= w_q;
                        end
`else
                        last_q  <= w_q;
`endif
                    end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        last_q    <= w_q;
                        grant_q   <= '0;
                        state_q   <= IDLE;
`ifdef UART_ARB_LOCK_EN
                        burst_q   <= '0;
`endif
                    end else if (wd_q != '1) begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ack      = ack_q;
    assign o_grant    = grant_q;
    assign o_tx_start = start_q;
    assign o_tx_byte  = byte_q;
    assign o_timeout  = timeout_q;
    assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; expected orders depend on UART_ARB_LOCK_EN.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 20;
    localparam int unsigned MB = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   i_req = '0;
    logic [8*N-1:0] i_data = '0;
    logic           i_tx_busy = 1'b0;
    logic           i_tx_done = 1'b0;
    logic [N-1:0]   o_ack;
    logic [N-1:0]   o_grant;
    logic           o_tx_start;
    logic [7:0]     o_tx_byte;
    logic           o_busy;
    logic           o_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO),
        .MAX_BURST      (MB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_grant    (o_grant),
        .o_tx_start (o_tx_start),
        .o_tx_byte  (o_tx_byte),
        .i_tx_busy  (i_tx_busy),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy),
        .o_timeout  (o_timeout)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // LAUNCH cycle, a few frame cycles, then one done pulse.
    task automatic finish_frame;
        tick();
        repeat (3) tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    // Waits (bounded) for an ack, reports the winner, launched byte and start pulse.
    task automatic do_frame(output int idx, output logic [7:0] b, output bit ok);
        bit got;
        got = 1'b0;
        idx = -1;
        b   = 8'hxx;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (|o_ack) got = 1'b1;
        end
        ok = got;
        if (got) begin
            for (int k = 0; k < N; k++) if (o_ack[k]) idx = k;
            tick();
            b = o_tx_byte;
            if (o_tx_start !== 1'b1) ok = 1'b0;
            repeat (5) tick();
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({o_ack, o_grant, o_tx_start, o_tx_byte, o_busy, o_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b grant=%b start=%b byte=%h busy=%b to=%b exp all zero",
                     o_ack, o_grant, o_tx_start, o_tx_byte, o_busy, o_timeout);
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        i_data = {8'h00, 8'h00, 8'h00, 8'hA5};
        i_req  = 4'b0001;
        tick();
        checks++;
        if (o_ack !== 4'b0001 || o_grant !== 4'b0001 || o_tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_capture got ack=%b grant=%b start=%b exp 0001 0001 0", o_ack, o_grant, o_tx_start);
        end
        i_req = '0;
        tick();
        checks++;
        if (o_tx_start !== 1'b1 || o_tx_byte !== 8'hA5 || o_ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_launch got start=%b byte=%h ack=%b exp 1 a5 0000", o_tx_start, o_tx_byte, o_ack);
        end
        tick();
        checks++;
        if (o_tx_start !== 1'b0 || o_busy !== 1'b1 || o_grant !== 4'b0001) begin
            errors++;
            $display("FAIL single_wait got start=%b busy=%b grant=%b exp 0 1 0001", o_tx_start, o_busy, o_grant);
        end
        repeat (3) tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        checks++;
        if (o_grant !== 4'b0000 || o_busy !== 1'b0 || o_tx_byte !== 8'hA5) begin
            errors++;
            $display("FAIL single_done got grant=%b busy=%b byte=%h exp 0000 0 a5", o_grant, o_busy, o_tx_byte);
        end
    endtask

    task automatic test_round_robin;
        int idx;
        logic [7:0] b;
        bit ok;
`ifdef UART_ARB_LOCK_EN
        int         exp_i[5] = '{0, 0, 1, 1, 2};
        logic [7:0] exp_b[5] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33};
`else
        int         exp_i[5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`endif
        do_reset();
        i_data = {8'h44, 8'h33, 8'h22, 8'h11};
        i_req  = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            do_frame(idx, b, ok);
            checks++;
            if (!ok || idx != exp_i[f] || b !== exp_b[f]) begin
                errors++;
                $display("FAIL rr_frame%0d got ok=%0d idx=%0d byte=%h exp idx=%0d byte=%h", f, ok, idx, b, exp_i[f], exp_b[f]);
            end
        end
        i_req = '0;
    endtask

    task automatic test_busy;
        bit early;
        early     = 1'b0;
        i_tx_busy = 1'b1;
        reset     = 1'b1;
        i_data    = {8'h00, 8'h00, 8'h3C, 8'h00};
        i_req     = 4'b0010;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_ack !== 4'b0000) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL busy_hold got ack while busy exp no ack");
        end
        i_tx_busy = 1'b0;
        tick();
        checks++;
        if (o_ack !== 4'b0010 || o_tx_byte !== 8'h3C) begin
            errors++;
            $display("FAIL busy_release got ack=%b byte=%h exp 0010 3c", o_ack, o_tx_byte);
        end
        i_req = '0;
        finish_frame();
    endtask

    task automatic test_timeout;
        int n;
        bit seen;
        do_reset();
        i_data = {8'h00, 8'h77, 8'h00, 8'h66};
        i_req  = 4'b0101;
        tick();
        checks++;
        if (o_ack !== 4'b0001) begin
            errors++;
            $display("FAIL to_first got ack=%b exp 0001", o_ack);
        end
        i_req = 4'b0100;
        tick();
        checks++;
        if (o_tx_start !== 1'b1) begin
            errors++;
            $display("FAIL to_start got start=%b exp 1", o_tx_start);
        end
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            n++;
            if (o_timeout === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != TO) begin
            errors++;
            $display("FAIL to_delay got seen=%0d cycles=%0d exp cycles=%0d", seen, n, TO);
        end
        checks++;
        if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL to_idle got grant=%b busy=%b exp 0000 0", o_grant, o_busy);
        end
        tick();
        checks++;
        if (o_ack !== 4'b0100 || o_timeout !== 1'b0 || o_tx_byte !== 8'h77) begin
            errors++;
            $display("FAIL to_next got ack=%b to=%b byte=%h exp 0100 0 77", o_ack, o_timeout, o_tx_byte);
        end
        i_req = '0;
        finish_frame();
    endtask

    task automatic test_reset_mid;
        do_reset();
        i_data = {8'h00, 8'h99, 8'h00, 8'h88};
        i_req  = 4'b0100;
        tick();
        checks++;
        if (o_ack !== 4'b0100) begin
            errors++;
            $display("FAIL mid_capture got ack=%b exp 0100", o_ack);
        end
        i_req = '0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({o_ack, o_grant, o_tx_start, o_tx_byte, o_busy, o_timeout} !== '0) begin
            errors++;
            $display("FAIL mid_reset got ack=%b grant=%b start=%b byte=%h busy=%b to=%b exp all zero",
                     o_ack, o_grant, o_tx_start, o_tx_byte, o_busy, o_timeout);
        end
        reset = 1'b0;
        i_req = 4'b0101;
        tick();
        checks++;
        if (o_ack !== 4'b0001 || o_tx_byte !== 8'h88) begin
            errors++;
            $display("FAIL mid_after got ack=%b byte=%h exp 0001 88", o_ack, o_tx_byte);
        end
        i_req = '0;
        finish_frame();
    endtask

    task automatic test_back_to_back;
        int idx;
        logic [7:0] b;
        bit ok;
`ifdef UART_ARB_LOCK_EN
        int exp_i[6] = '{0, 0, 1, 1, 0, 0};
`else
        int exp_i[6] = '{0, 1, 0, 1, 0, 1};
`endif
        logic [7:0] exp_b;
        do_reset();
        i_data = {8'h00, 8'h00, 8'h66, 8'h55};
        i_req  = 4'b0011;
        for (int f = 0; f < 6; f++) begin
            do_frame(idx, b, ok);
            exp_b = (exp_i[f] == 0) ? 8'h55 : 8'h66;
            checks++;
            if (!ok || idx != exp_i[f] || b !== exp_b) begin
                errors++;
                $display("FAIL b2b_frame%0d got ok=%0d idx=%0d byte=%h exp idx=%0d byte=%h", f, ok, idx, b, exp_i[f], exp_b);
            end
        end
        i_req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion exp finish before 200000");
        $fatal(1);
    end

endmodule
